// File: rtl/fixed_point_mac_pkg.sv
// Shared fixed-point helpers: format widths, saturation limits and rounding mode.
// Imported by the MAC top and its round/saturate sub-block.
package fixed_point_mac_pkg;

   typedef enum logic {
      RND_TRUNC   = 1'b0,
      RND_HALF_UP = 1'b1
   } rnd_mode_t;

   // Sideband that travels alongside each beat through the pipeline
   typedef struct packed {
      logic      last;
      rnd_mode_t rnd;
   } side_t;

   function automatic int fxp_width(input int m, input int q);
      return m + q + 1;
   endfunction

   function automatic longint fxp_max(input int width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   function automatic longint fxp_min(input int width);
      return -(64'sd1 <<< (width - 1));
   endfunction

   // Half an LSB of the shifted result; zero when nothing is shifted out
   function automatic longint fxp_half(input int shift);
      longint h;
      h = 64'sd0;
      if (shift > 0) h = 64'sd1 <<< (shift - 1);
      return h;
   endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational arithmetic right shift with optional round-half-up and
// saturation to a narrower signed format.
module fxp_round_sat
   import fixed_point_mac_pkg::*;
#(
   parameter int IN_W  = 24,
   parameter int SHIFT = 4,
   parameter int OUT_W = 8
) (
   input  logic signed [IN_W-1:0]  din,
   input  rnd_mode_t               rnd,
   output logic signed [OUT_W-1:0] dout,
   output logic                    ovf
);

   // One spare bit so the rounding increment cannot wrap the input
   localparam int EW = IN_W + 1;
   localparam logic signed [EW-1:0] HALF = EW'(fxp_half(SHIFT));
   localparam logic signed [EW-1:0] MAXV = EW'(fxp_max(OUT_W));
   localparam logic signed [EW-1:0] MINV = EW'(fxp_min(OUT_W));

   logic signed [EW-1:0] biased;
   logic signed [EW-1:0] shifted;

   always_comb begin
      biased = {din[IN_W-1], din};
      if (rnd == RND_HALF_UP) biased = biased + HALF;
      shifted = biased >>> SHIFT;
      dout    = shifted[OUT_W-1:0];
      ovf     = 1'b0;
      if (shifted > MAXV) begin
         dout = MAXV[OUT_W-1:0];
         ovf  = 1'b1;
      end else if (shifted < MINV) begin
         dout = MINV[OUT_W-1:0];
         ovf  = 1'b1;
      end
   end

endmodule

// File: rtl/fixed_point_mac.sv
// Pipelined fixed-point multiply-accumulate: full-precision frame accumulation,
// one rounded/saturated result per frame, single global stall enable.
module fixed_point_mac
   import fixed_point_mac_pkg::*;
#(
   parameter int A_M   = 3,
   parameter int A_Q   = 4,
   parameter int B_M   = 3,
   parameter int B_Q   = 4,
   parameter int OUT_M = 3,
   parameter int OUT_Q = 4,
   parameter int GUARD = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [A_M+A_Q:0]    in_a,
   input  logic signed [B_M+B_Q:0]    in_b,
   input  logic                       in_last,
   input  logic                       in_rnd,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [OUT_M+OUT_Q:0] out_data,
   output logic                       out_ovf
);

   localparam int A_W    = fxp_width(A_M, A_Q);
   localparam int B_W    = fxp_width(B_M, B_Q);
   localparam int OUT_W  = fxp_width(OUT_M, OUT_Q);
   localparam int P_W    = A_W + B_W;
   localparam int ACC_W  = P_W + GUARD;
   localparam int SHIFT  = A_Q + B_Q - OUT_Q;
   localparam int STAGES = 3;

   if (OUT_Q > A_Q + B_Q) begin : g_bad_out_q
      $error("fixed_point_mac: OUT_Q must not exceed A_Q+B_Q");
   end

   logic                      en;
   logic [STAGES:1]           vld_pipe;
   side_t                     side1, side2;
   logic signed [P_W-1:0]     prod_c, prod;
   logic signed [ACC_W-1:0]   acc;
   logic                      first;
   logic signed [OUT_W-1:0]   rs_data, conv_data;
   logic                      rs_ovf, conv_ovf;
   logic                      conv_load;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;
   assign prod_c   = in_a * in_b;

   // Stage 1: exact product
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe[1] <= 1'b0;
         side1       <= '{last: 1'b0, rnd: RND_TRUNC};
         prod        <= '0;
      end else if (en) begin
         vld_pipe[1] <= in_valid;
         if (in_valid) begin
            prod  <= prod_c;
            side1 <= '{last: in_last, rnd: rnd_mode_t'(in_rnd)};
         end
      end
   end

   // Stage 2: accumulate; first restarts the sum at the next frame boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe[2] <= 1'b0;
         side2       <= '{last: 1'b0, rnd: RND_TRUNC};
         acc         <= '0;
         first       <= 1'b1;
      end else if (en) begin
         vld_pipe[2] <= vld_pipe[1];
         if (vld_pipe[1]) begin
            side2 <= side1;
            acc   <= (first ? '0 : acc) + {{GUARD{prod[P_W-1]}}, prod};
            first <= side1.last;
         end
      end
   end

   fxp_round_sat #(
      .IN_W  (ACC_W),
      .SHIFT (SHIFT),
      .OUT_W (OUT_W)
   ) u_round_sat (
      .din  (acc),
      .rnd  (side2.rnd),
      .dout (rs_data),
      .ovf  (rs_ovf)
   );

   assign conv_load = vld_pipe[2] && side2.last;

   // Stage 3: registered conversion, only for frame-closing beats
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe[3] <= 1'b0;
         conv_data   <= '0;
         conv_ovf    <= 1'b0;
      end else if (en) begin
         vld_pipe[3] <= conv_load;
         if (conv_load) begin
            conv_data <= rs_data;
            conv_ovf  <= rs_ovf;
         end
      end
   end

   // Output register; holds while the consumer stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ovf   <= 1'b0;
      end else if (en) begin
         out_valid <= vld_pipe[3];
         if (vld_pipe[3]) begin
            out_data <= conv_data;
            out_ovf  <= conv_ovf;
         end
      end
   end

endmodule

// File: tb/tb_fixed_point_mac.sv
// Scoreboard bench for fixed_point_mac: directed scenarios plus random frames
// checked against an integer-arithmetic reference of the fixed-point rules.
module tb_fixed_point_mac;

   localparam int ACC_W = 24;
   localparam int SHIFT = 4;

   typedef struct {
      logic [7:0] data;
      logic       ovf;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic signed [7:0] in_a, in_b;
   logic              in_last, in_rnd;
   logic              out_valid;
   logic              out_ready;
   logic signed [7:0] out_data;
   logic              out_ovf;

   logic man_rdy, rand_rdy, rr;
   assign out_ready = rand_rdy ? rr : man_rdy;

   exp_t   q[$];
   longint sum;
   int     n_chk = 0;
   int     n_fail = 0;

   fixed_point_mac dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .in_rnd    (in_rnd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: exact integer sum, wrapped to the accumulator width, then
   // scaled by 2^-SHIFT with floor (optionally after adding half an LSB).
   function automatic exp_t ref_conv(input longint s, input bit rnd);
      exp_t   e;
      longint w, qv, m;
      m = longint'(1) << ACC_W;
      w = ((s % m) + m) % m;
      if (w >= m / 2) w = w - m;
      if (rnd) w = w + (1 << (SHIFT - 1));
      qv = (w - (((w % 16) + 16) % 16)) / 16;
      if (qv > 127) begin
         e.data = 8'h7F; e.ovf = 1'b1;
      end else if (qv < -128) begin
         e.data = 8'h80; e.ovf = 1'b1;
      end else begin
         e.data = 8'(qv); e.ovf = 1'b0;
      end
      return e;
   endfunction

   task automatic send_beat(input logic [7:0] a, input logic [7:0] b,
                            input bit last, input bit rnd);
      int n;
      bit took;
      n = 0;
      took = 1'b0;
      in_a = a; in_b = b; in_last = last; in_rnd = rnd; in_valid = 1'b1;
      while (!took && n < 200) begin
         @(negedge clk);
         took = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (!took) begin
         chk("accept_timeout", 0, 1);
      end else begin
         sum += longint'($signed(a)) * longint'($signed(b));
         if (last) begin
            q.push_back(ref_conv(sum, rnd));
            sum = 0;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_out_valid(input string name);
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(name, out_valid, 1);
   endtask

   // Monitor: pops an expectation on each output handshake
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_output", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("out_data", longint'(out_data), longint'($signed(e.data)));
            chk("out_ovf", out_ovf, e.ovf);
         end
      end
   end

   always @(posedge clk) begin
      #1;
      rr = ($urandom_range(0, 3) != 0);
   end

   initial begin
      logic [7:0] snap;
      int n;
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
      in_rnd = 1'b0; man_rdy = 1'b1; rand_rdy = 1'b0; sum = 0;
      idle(2);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_ovf", out_ovf, 0);
      rst = 1'b0;
      idle(1);

      // 1: single beat and exact latency
      send_beat(8'h18, 8'h20, 1, 0);
      idle(1); chk("lat_t1", out_valid, 0);
      idle(1); chk("lat_t2", out_valid, 0);
      idle(1); chk("lat_t3", out_valid, 1);
      idle(2);

      // 2: back-to-back frame then immediate one-beat frame
      for (int i = 0; i < 4; i++) send_beat(8'h08, 8'h08, i == 3, 0);
      send_beat(8'h10, 8'h10, 1, 0);
      idle(4);

      // 3: rounding modes
      send_beat(8'h01, 8'h08, 1, 0);
      send_beat(8'h01, 8'h08, 1, 1);
      idle(4);

      // 4: saturation both ways, then a clean frame
      send_beat(8'h7F, 8'h7F, 1, 0);
      send_beat(8'h80, 8'h7F, 1, 1);
      send_beat(8'h10, 8'h10, 1, 0);
      idle(5);

      // 5: consumer stall with a result pending
      man_rdy = 1'b0;
      send_beat(8'h18, 8'h18, 1, 0);
      wait_out_valid("stall_out_valid");
      snap = out_data;
      fork
         send_beat(8'h20, 8'hF0, 1, 1);
         begin
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               chk("stall_in_ready", in_ready, 0);
               chk("stall_data", out_data, snap);
               @(posedge clk);
               #1;
            end
            man_rdy = 1'b1;
         end
      join
      idle(6);

      // 6: reset discards a partial frame
      send_beat(8'h7F, 8'h7F, 0, 0);
      send_beat(8'h7F, 8'h7F, 0, 0);
      rst = 1'b1;
      sum = 0;
      idle(1);
      rst = 1'b0;
      idle(1);
      send_beat(8'h10, 8'h20, 1, 0);
      idle(6);

      // Random frames with bubbles and random back-pressure
      rand_rdy = 1'b1;
      for (int f = 0; f < 40; f++) begin
         int len;
         bit rnd;
         len = $urandom_range(1, 6);
         rnd = $urandom_range(0, 1) == 1;
         for (int i = 0; i < len; i++) begin
            send_beat(8'($urandom), 8'($urandom), i == len - 1, rnd);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         end
      end

      n = 0;
      while (q.size() != 0 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain", q.size(), 0);
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
